// File: rtl/vx_mem_req_arb_pkg.sv
// Shared helpers for the memory request arbiter: channel-index width and
// the tag extend/strip functions that carry the source channel in the tag LSBs.
package vx_mem_req_arb_pkg;

   localparam int TAG_MAXW = 64;
   typedef logic [TAG_MAXW-1:0] tag_bus_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // A single channel needs no index bits at all.
   function automatic int req_idx_bits(input int n);
      return (n > 1) ? clog2(n) : 0;
   endfunction

   function automatic tag_bus_t tag_extend(input tag_bus_t tag, input tag_bus_t idx, input int log_n);
      return (tag << log_n) | idx;
   endfunction

   function automatic tag_bus_t tag_strip(input tag_bus_t tag, input int log_n);
      return tag >> log_n;
   endfunction

endpackage

// File: rtl/vx_skid_buffer.sv
// Two-entry valid/ready buffer with a registered head; latency 1 cycle, full rate.
// Backpressure: ready_in drops when both entries are occupied or during reset.
module vx_skid_buffer #(
   parameter int DATAW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [DATAW-1:0] data_in,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [DATAW-1:0] data_out
);

   logic [1:0]       count;
   logic [DATAW-1:0] head;
   logic [DATAW-1:0] tail;
   logic             push;
   logic             pop;

   assign ready_in  = (count != 2'd2) && !reset;
   assign valid_out = (count != 2'd0);
   assign data_out  = head;
   assign push      = valid_in && ready_in;
   assign pop       = valid_out && ready_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= data_in;
               else               tail <= data_in;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            // Push and pop together only happen with one entry held.
            2'b11: head <= data_in;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vx_mem_req_arb.sv
// Round-robin N:1 memory request arbiter with channel-tagged 1:N response demux.
// Latency 0 (BUFFERED=0) or 1 (skid buffer); responses are combinational, ready follows the addressed channel.
module vx_mem_req_arb
   import vx_mem_req_arb_pkg::*;
#(
   parameter int NUM_REQS      = 4,
   parameter int DATA_WIDTH    = 512,
   parameter int DATA_SIZE     = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH    = 26,
   parameter int TAG_IN_WIDTH  = 8,
   parameter int LOG_NUM_REQS  = req_idx_bits(NUM_REQS),
   parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS,
   parameter int BUFFERED      = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQS-1:0]             req_valid_in,
   input  logic [NUM_REQS-1:0]             req_rw_in,
   input  logic [NUM_REQS*DATA_SIZE-1:0]   req_byteen_in,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr_in,
   input  logic [NUM_REQS*DATA_WIDTH-1:0]  req_data_in,
   input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
   output logic [NUM_REQS-1:0]             req_ready_in,
   output logic                            mem_req_valid,
   output logic                            mem_req_rw,
   output logic [DATA_SIZE-1:0]            mem_req_byteen,
   output logic [ADDR_WIDTH-1:0]           mem_req_addr,
   output logic [DATA_WIDTH-1:0]           mem_req_data,
   output logic [TAG_OUT_WIDTH-1:0]        mem_req_tag,
   input  logic                            mem_req_ready,
   input  logic                            mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]           mem_rsp_data,
   input  logic [TAG_OUT_WIDTH-1:0]        mem_rsp_tag,
   output logic                            mem_rsp_ready,
   output logic [NUM_REQS-1:0]             rsp_valid_out,
   output logic [DATA_WIDTH-1:0]           rsp_data_out,
   output logic [TAG_IN_WIDTH-1:0]         rsp_tag_out,
   input  logic [NUM_REQS-1:0]             rsp_ready_out
);

   localparam int IDXW = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;
   localparam int REQW = 1 + DATA_SIZE + ADDR_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;

   logic [IDXW-1:0] ptr;
   logic [IDXW-1:0] grant;
   logic            found;
   int              j;
   int              gi;
   logic            any_valid;
   logic            in_ready;
   logic            in_fire;
   tag_bus_t        gnt_tag_ext;
   tag_bus_t        rsp_tag_ext;
   logic            unused_tag_hi;
   logic [REQW-1:0] in_dat;
   logic [REQW-1:0] out_dat;
   logic [IDXW-1:0] rsp_idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQS) j = j - NUM_REQS;
         if (!found && req_valid_in[j +: 1] == 1'b1) begin
            found = 1'b1;
            grant = IDXW'(j);
         end
      end
   end

   assign gi        = int'(grant);
   assign any_valid = |req_valid_in;
   assign in_fire   = any_valid && in_ready;

   always_comb begin
      req_ready_in = '0;
      for (int i = 0; i < NUM_REQS; i++)
         if (grant == IDXW'(i)) req_ready_in[i] = in_ready;
   end

   generate
      if (NUM_REQS > 1) begin : g_ptr
         always_ff @(posedge clk) begin
            if (reset)
               ptr <= '0;
            else if (in_fire)
               ptr <= (gi == NUM_REQS - 1) ? '0 : grant + IDXW'(1);
         end
      end else begin : g_no_ptr
         assign ptr = '0;
      end
   endgenerate

   assign gnt_tag_ext = tag_extend(tag_bus_t'(req_tag_in[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH]),
                                   tag_bus_t'(grant), LOG_NUM_REQS);
   assign in_dat = {req_rw_in[gi +: 1],
                    req_byteen_in[gi*DATA_SIZE +: DATA_SIZE],
                    req_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH],
                    req_data_in[gi*DATA_WIDTH +: DATA_WIDTH],
                    gnt_tag_ext[TAG_OUT_WIDTH-1:0]};

   generate
      if (BUFFERED != 0) begin : g_buf
         vx_skid_buffer #(.DATAW(REQW)) u_buf (
            .clk       (clk),
            .reset     (reset),
            .valid_in  (any_valid),
            .ready_in  (in_ready),
            .data_in   (in_dat),
            .valid_out (mem_req_valid),
            .ready_out (mem_req_ready),
            .data_out  (out_dat)
         );
      end else begin : g_comb
         assign mem_req_valid = any_valid;
         assign in_ready      = mem_req_ready;
         assign out_dat       = in_dat;
      end
   endgenerate

   assign {mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag} = out_dat;

   generate
      if (LOG_NUM_REQS > 0) begin : g_idx
         assign rsp_idx = mem_rsp_tag[LOG_NUM_REQS-1:0];
      end else begin : g_no_idx
         assign rsp_idx = '0;
      end
   endgenerate

   // An index beyond NUM_REQS-1 matches no channel, so nobody sees valid.
   always_comb begin
      rsp_valid_out = '0;
      mem_rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (rsp_idx == IDXW'(i)) begin
            rsp_valid_out[i] = mem_rsp_valid;
            mem_rsp_ready    = rsp_ready_out[i];
         end
      end
   end

   assign rsp_tag_ext   = tag_strip(tag_bus_t'(mem_rsp_tag), LOG_NUM_REQS);
   assign rsp_tag_out   = rsp_tag_ext[TAG_IN_WIDTH-1:0];
   assign rsp_data_out  = mem_rsp_data;
   assign unused_tag_hi = ^{gnt_tag_ext[TAG_MAXW-1:TAG_OUT_WIDTH], rsp_tag_ext[TAG_MAXW-1:TAG_IN_WIDTH]};

   generate
      for (genvar i = 0; i < NUM_REQS; i++) begin : g_in_hold
         assert property (@(posedge clk) disable iff (reset)
            (req_valid_in[i] && !req_ready_in[i]) |=>
            (req_valid_in[i] && $stable({req_rw_in[i],
                                         req_byteen_in[i*DATA_SIZE +: DATA_SIZE],
                                         req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH],
                                         req_data_in[i*DATA_WIDTH +: DATA_WIDTH],
                                         req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH]})));
      end
   endgenerate

   assert property (@(posedge clk) disable iff (reset)
      (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(out_dat)));
   assert property (@(posedge clk) $onehot0(rsp_valid_out));
   assert property (@(posedge clk) disable iff (reset)
      mem_rsp_valid |-> (int'(rsp_idx) < NUM_REQS));

endmodule

// File: tb/tb_vx_mem_req_arb.sv
// Directed bench for vx_mem_req_arb: a 4-channel buffered instance and a
// 1-channel combinational instance, with a response-demux vector table.
module tb_vx_mem_req_arb;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 4-channel, buffered instance
   logic [3:0]    req_valid_in, req_rw_in, req_ready_in;
   logic [255:0]  req_byteen_in;
   logic [103:0]  req_addr_in;
   logic [2047:0] req_data_in;
   logic [31:0]   req_tag_in;
   logic          mem_req_valid, mem_req_rw, mem_req_ready;
   logic [63:0]   mem_req_byteen;
   logic [25:0]   mem_req_addr;
   logic [511:0]  mem_req_data;
   logic [9:0]    mem_req_tag;
   logic          mem_rsp_valid, mem_rsp_ready;
   logic [511:0]  mem_rsp_data, rsp_data_out;
   logic [9:0]    mem_rsp_tag;
   logic [3:0]    rsp_valid_out, rsp_ready_out;
   logic [7:0]    rsp_tag_out;

   // 1-channel, combinational instance
   logic          r1_valid, r1_rw, r1_ready;
   logic [3:0]    r1_byteen;
   logic [25:0]   r1_addr;
   logic [31:0]   r1_data;
   logic [7:0]    r1_tag;
   logic          m1_valid, m1_rw, m1_ready;
   logic [3:0]    m1_byteen;
   logic [25:0]   m1_addr;
   logic [31:0]   m1_data;
   logic [7:0]    m1_tag;
   logic          m1_rsp_valid, m1_rsp_ready;
   logic [31:0]   m1_rsp_data, o1_data;
   logic [7:0]    m1_rsp_tag, o1_tag;
   logic [0:0]    o1_valid, o1_ready;

   vx_mem_req_arb #(.NUM_REQS(4), .DATA_WIDTH(512), .ADDR_WIDTH(26), .TAG_IN_WIDTH(8), .BUFFERED(1)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
      .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
      .req_ready_in(req_ready_in),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
      .mem_rsp_ready(mem_rsp_ready),
      .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
      .rsp_ready_out(rsp_ready_out)
   );

   vx_mem_req_arb #(.NUM_REQS(1), .DATA_WIDTH(32), .ADDR_WIDTH(26), .TAG_IN_WIDTH(8), .BUFFERED(0)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid_in(r1_valid), .req_rw_in(r1_rw), .req_byteen_in(r1_byteen),
      .req_addr_in(r1_addr), .req_data_in(r1_data), .req_tag_in(r1_tag),
      .req_ready_in(r1_ready),
      .mem_req_valid(m1_valid), .mem_req_rw(m1_rw), .mem_req_byteen(m1_byteen),
      .mem_req_addr(m1_addr), .mem_req_data(m1_data), .mem_req_tag(m1_tag),
      .mem_req_ready(m1_ready),
      .mem_rsp_valid(m1_rsp_valid), .mem_rsp_data(m1_rsp_data), .mem_rsp_tag(m1_rsp_tag),
      .mem_rsp_ready(m1_rsp_ready),
      .rsp_valid_out(o1_valid), .rsp_data_out(o1_data), .rsp_tag_out(o1_tag),
      .rsp_ready_out(o1_ready)
   );

   typedef struct {
      logic        v;
      logic [9:0]  tag;
      logic [3:0]  rdy;
      logic [31:0] dat;
      logic [3:0]  e_vout;
      logic [7:0]  e_tag;
      logic        e_mrdy;
   } rsp_vec_t;

   rsp_vec_t   vecs [6];
   int         n_pass  = 0;
   int         n_total = 0;
   logic [9:0] exp_tag;
   logic [3:0] exp_rdy;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_ch(input int ch, input logic [7:0] tag, input logic [25:0] addr);
      req_tag_in[ch*8 +: 8]         = tag;
      req_addr_in[ch*26 +: 26]      = addr;
      req_data_in[ch*512 +: 512]    = 512'(addr);
      req_byteen_in[ch*64 +: 64]    = '1;
      req_rw_in[ch]                 = tag[0];
   endtask

   // Inputs are held across the first reset edge, then cleared.
   task automatic do_reset();
      reset = 1'b1;
      step();
      req_valid_in  = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 10'h3C1, 4'b0010, 32'h1111_0000, 4'b0010, 8'hF0, 1'b1};
      vecs[1] = '{1'b1, 10'h3C1, 4'b1101, 32'h2222_0000, 4'b0010, 8'hF0, 1'b0};
      vecs[2] = '{1'b0, 10'h3C1, 4'b1111, 32'h3333_0000, 4'b0000, 8'hF0, 1'b1};
      vecs[3] = '{1'b1, 10'h000, 4'b0001, 32'h4444_0000, 4'b0001, 8'h00, 1'b1};
      vecs[4] = '{1'b1, 10'h2AB, 4'b0111, 32'h5555_0000, 4'b1000, 8'hAA, 1'b0};
      vecs[5] = '{1'b1, 10'h1FE, 4'b0100, 32'h6666_0000, 4'b0100, 8'h7F, 1'b1};

      reset = 1'b1;
      req_valid_in = 4'hF; req_rw_in = '0; req_byteen_in = '0;
      req_addr_in = '0; req_data_in = '0; req_tag_in = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      mem_rsp_tag = '0; rsp_ready_out = '0;
      r1_valid = 1'b0; r1_rw = 1'b0; r1_byteen = '0; r1_addr = '0; r1_data = '0;
      r1_tag = '0; m1_ready = 1'b0; m1_rsp_valid = 1'b0; m1_rsp_data = '0;
      m1_rsp_tag = '0; o1_ready = '0;

      // Reset state, with every channel requesting
      step(); mid();
      check("rst_mem_valid", 512'(mem_req_valid), 512'(1'b0));
      check("rst_ready_in", 512'(req_ready_in), 512'(4'b0000));
      check("rst_rsp_valid", 512'(rsp_valid_out), 512'(4'b0000));
      req_valid_in = '0;
      step();
      reset = 1'b0;

      // Round robin, all channels valid, memory always ready
      for (int i = 0; i < 4; i++) set_ch(i, 8'(i), 26'(i));
      req_valid_in = 4'hF; mem_req_ready = 1'b1;
      mid();
      check("rr_first_latency", 512'(mem_req_valid), 512'(1'b0));
      check("rr_first_ready", 512'(req_ready_in), 512'(4'b0001));
      for (int c = 0; c < 5; c++) begin
         step(); mid();
         exp_tag = {8'(c % 4), 2'(c % 4)};
         exp_rdy = 4'(1 << ((c + 1) % 4));
         check("rr_valid", 512'(mem_req_valid), 512'(1'b1));
         check("rr_tag", 512'(mem_req_tag), 512'(exp_tag));
         check("rr_ready", 512'(req_ready_in), 512'(exp_rdy));
      end
      do_reset();

      // Single channel 2 request
      set_ch(2, 8'h5A, 26'h123);
      req_valid_in = 4'b0100; mem_req_ready = 1'b1;
      mid();
      check("ch2_ready", 512'(req_ready_in), 512'(4'b0100));
      step();
      req_valid_in = 4'hF;
      mid();
      check("ch2_tag", 512'(mem_req_tag), 512'(10'h16A));
      check("ch2_addr", 512'(mem_req_addr), 512'(26'h123));
      check("ch2_next_grant3", 512'(req_ready_in), 512'(4'b1000));
      do_reset();

      // Backpressure: memory stalled for 5 cycles, channels 0 and 1
      set_ch(0, 8'h10, 26'h40); set_ch(1, 8'h11, 26'h41);
      req_valid_in = 4'b0011; mem_req_ready = 1'b0;
      mid();
      check("bp_ready0", 512'(req_ready_in), 512'(4'b0001));
      check("bp_valid0", 512'(mem_req_valid), 512'(1'b0));
      step();
      req_valid_in = 4'b0010;
      mid();
      check("bp_ready1", 512'(req_ready_in), 512'(4'b0010));
      check("bp_head_tag", 512'(mem_req_tag), 512'(10'h040));
      check("bp_head_addr", 512'(mem_req_addr), 512'(26'h40));
      step();
      set_ch(0, 8'h20, 26'h60); set_ch(1, 8'h21, 26'h61);
      req_valid_in = 4'b0011;
      for (int c = 0; c < 3; c++) begin
         mid();
         check("bp_full_ready", 512'(req_ready_in), 512'(4'b0000));
         check("bp_stable_tag", 512'(mem_req_tag), 512'(10'h040));
         step();
      end
      mem_req_ready = 1'b1;
      mid();
      check("bp_release_tag", 512'(mem_req_tag), 512'(10'h040));
      check("bp_release_ready", 512'(req_ready_in), 512'(4'b0000));
      step(); mid();
      check("bp_second_tag", 512'(mem_req_tag), 512'(10'h045));
      check("bp_after_pop_ready", 512'(req_ready_in), 512'(4'b0001));
      step();
      req_valid_in = 4'b0010;
      mid();
      check("bp_third_tag", 512'(mem_req_tag), 512'(10'h080));
      check("bp_third_ready", 512'(req_ready_in), 512'(4'b0010));
      step();
      req_valid_in = 4'b0000;
      mid();
      check("bp_fourth_tag", 512'(mem_req_tag), 512'(10'h085));
      step(); mid();
      check("bp_drained", 512'(mem_req_valid), 512'(1'b0));
      do_reset();

      // Reset with two buffered entries
      set_ch(0, 8'h30, 26'h50); set_ch(1, 8'h31, 26'h51);
      req_valid_in = 4'b0011; mem_req_ready = 1'b0;
      step();
      req_valid_in = 4'b0010;
      step();
      req_valid_in = 4'b0000;
      step();
      check("full_before_rst", 512'(mem_req_valid), 512'(1'b1));
      reset = 1'b1; mem_req_ready = 1'b1;
      mid();
      check("midrst_ready", 512'(req_ready_in), 512'(4'b0000));
      step();
      reset = 1'b0; req_valid_in = 4'hF; mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) set_ch(i, 8'(8'h40 + i), 26'(i));
      mid();
      check("midrst_dropped", 512'(mem_req_valid), 512'(1'b0));
      check("midrst_grant0", 512'(req_ready_in), 512'(4'b0001));
      step(); mid();
      check("midrst_out_tag", 512'(mem_req_tag), 512'(10'h100));
      do_reset();

      // Response demux vectors
      for (int n = 0; n < 6; n++) begin
         mem_rsp_valid = vecs[n].v;
         mem_rsp_tag   = vecs[n].tag;
         rsp_ready_out = vecs[n].rdy;
         mem_rsp_data  = 512'(vecs[n].dat);
         mid();
         check("rsp_valid", 512'(rsp_valid_out), 512'(vecs[n].e_vout));
         check("rsp_tag", 512'(rsp_tag_out), 512'(vecs[n].e_tag));
         check("rsp_mem_ready", 512'(mem_rsp_ready), 512'(vecs[n].e_mrdy));
         check("rsp_data", rsp_data_out, 512'(vecs[n].dat));
         step();
      end
      mem_rsp_valid = 1'b0;

      // Single channel, combinational path
      r1_valid = 1'b1; r1_rw = 1'b1; r1_byteen = 4'hA; r1_addr = 26'h2BCDEF;
      r1_data = 32'hDEADBEEF; r1_tag = 8'hA7; m1_ready = 1'b0;
      #1;
      check("n1_valid", 512'(m1_valid), 512'(1'b1));
      check("n1_tag", 512'(m1_tag), 512'(8'hA7));
      check("n1_addr", 512'(m1_addr), 512'(26'h2BCDEF));
      check("n1_data", 512'(m1_data), 512'(32'hDEADBEEF));
      check("n1_byteen_rw", 512'({m1_byteen, m1_rw}), 512'({4'hA, 1'b1}));
      check("n1_ready_low", 512'(r1_ready), 512'(1'b0));
      step();
      m1_ready = 1'b1;
      #1;
      check("n1_ready_high", 512'(r1_ready), 512'(1'b1));
      step();
      r1_valid = 1'b0;
      #1;
      check("n1_idle", 512'(m1_valid), 512'(1'b0));
      m1_rsp_valid = 1'b1; m1_rsp_tag = 8'h3C; m1_rsp_data = 32'h1234_5678; o1_ready = 1'b0;
      #1;
      check("n1_rsp_valid", 512'(o1_valid), 512'(1'b1));
      check("n1_rsp_tag", 512'(o1_tag), 512'(8'h3C));
      check("n1_rsp_data", 512'(o1_data), 512'(32'h1234_5678));
      check("n1_rsp_ready0", 512'(m1_rsp_ready), 512'(1'b0));
      o1_ready = 1'b1;
      #1;
      check("n1_rsp_ready1", 512'(m1_rsp_ready), 512'(1'b1));
      m1_rsp_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
